// File: rtl/systolic_seq_cu_pkg.sv
// Shared types and defaults for the systolic array sequencer.
package systolic_seq_cu_pkg;

  localparam int unsigned DefN    = 4;
  localparam int unsigned DefDw   = 16;
  localparam int unsigned DefKmax = 16;
  localparam int unsigned DefAw   = 16;
  localparam int unsigned DefAccw = 2 * DefDw + $clog2(DefKmax);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StWb,
    StDone
  } state_e;

  // Cycles needed after the last read: read latency + skew + propagation.
  function automatic int unsigned drain_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_seq_cu_skew_buffer.sv
// Triangular skew register: lane i is delayed by i enabled cycles, lane 0 passes through.
module systolic_seq_cu_skew_buffer
  import systolic_seq_cu_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDw
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [N*DW-1:0] din_i,
  output logic [N*DW-1:0] dout_o
);

  assign dout_o[DW-1:0] = din_i[DW-1:0];

  for (genvar i = 1; i < N; i++) begin : g_lane
    logic [DW-1:0] sr_q [i];

    // Shift lane i by one stage per enabled cycle; clear wipes the whole lane.
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        for (int d = 0; d < i; d++) sr_q[d] <= '0;
      end else if (en_i) begin
        sr_q[0] <= din_i[i*DW +: DW];
        for (int d = 1; d < i; d++) sr_q[d] <= sr_q[d-1];
      end
    end

    assign dout_o[i*DW +: DW] = sr_q[i-1];
  end

endmodule

// File: rtl/systolic_seq_cu.sv
// Sequencer for an NxN output-stationary PE array: feed, drain, write back.
module systolic_seq_cu
  import systolic_seq_cu_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned DW   = DefDw,
  parameter int unsigned KMAX = DefKmax,
  parameter int unsigned ACCW = 2 * DW + $clog2(KMAX),
  parameter int unsigned AW   = DefAw
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ap_start,
  input  logic [$clog2(KMAX):0]  k_len,
  input  logic [AW-1:0]          o_base,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic [AW-1:0]          a_addr,
  output logic [AW-1:0]          b_addr,
  output logic                   ab_ren,
  input  logic [N*DW-1:0]        a_rdata,
  input  logic [N*DW-1:0]        b_rdata,
  output logic                   pe_clr,
  output logic                   pe_en,
  output logic [N*DW-1:0]        row_in,
  output logic [N*DW-1:0]        col_in,
  input  logic [N*N*ACCW-1:0]    pe_acc,
  output logic                   o_we,
  output logic [AW-1:0]          o_addr,
  output logic [ACCW-1:0]        o_wdata
);

  localparam int unsigned KW       = $clog2(KMAX) + 1;
  localparam int unsigned DrainLen = drain_len(N);
  localparam int unsigned CntMax   = (N * N > KMAX) ? N * N : KMAX;
  localparam int unsigned CW       = $clog2(CntMax + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_eff_q, k_eff_d;
  logic [AW-1:0]   o_base_q, o_base_d;
  logic            rd_valid_q;
  logic [N*DW-1:0] a_feed, b_feed;

  // State, counters and the read-data-valid flag that trails ab_ren by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      k_eff_q    <= '0;
      o_base_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_eff_q    <= k_eff_d;
      o_base_q   <= o_base_d;
      rd_valid_q <= ab_ren;
    end
  end

  // Next-state, counter sequencing and all memory/PE control outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_eff_d  = k_eff_q;
    o_base_d = o_base_q;
    ap_done  = 1'b0;
    ab_ren   = 1'b0;
    a_addr   = '0;
    b_addr   = '0;
    pe_clr   = 1'b0;
    pe_en    = 1'b0;
    o_we     = 1'b0;
    o_addr   = '0;
    o_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (ap_start) begin
          k_eff_d  = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
          o_base_d = o_base;
          cnt_d    = '0;
          state_d  = StClear;
        end
      end
      StClear: begin
        pe_clr  = 1'b1;
        cnt_d   = '0;
        state_d = (k_eff_q == '0) ? StDrain : StFeed;
      end
      StFeed: begin
        ab_ren = 1'b1;
        pe_en  = 1'b1;
        a_addr = AW'(cnt_q);
        b_addr = AW'(cnt_q);
        if (cnt_q == CW'(k_eff_q) - CW'(1)) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDrain: begin
        pe_en = 1'b1;
        if (cnt_q == CW'(DrainLen - 1)) begin
          cnt_d   = '0;
          state_d = StWb;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWb: begin
        o_we   = 1'b1;
        o_addr = o_base_q + AW'(cnt_q);
        for (int p = 0; p < N * N; p++) begin
          if (cnt_q == CW'(p)) o_wdata = pe_acc[p*ACCW +: ACCW];
        end
        if (cnt_q == CW'(N * N - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        ap_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign ap_idle = (state_q == StIdle);

  // Read data only counts in the cycle after a read; otherwise zeros enter the skew.
  assign a_feed = rd_valid_q ? a_rdata : '0;
  assign b_feed = rd_valid_q ? b_rdata : '0;

  systolic_seq_cu_skew_buffer #(
    .N  (N),
    .DW (DW)
  ) u_row_skew (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (pe_clr),
    .en_i   (pe_en),
    .din_i  (a_feed),
    .dout_o (row_in)
  );

  systolic_seq_cu_skew_buffer #(
    .N  (N),
    .DW (DW)
  ) u_col_skew (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (pe_clr),
    .en_i   (pe_en),
    .din_i  (b_feed),
    .dout_o (col_in)
  );

endmodule

// File: doc/systolic_seq_cu.md
Name: systolic_seq_cu

Overview:
- Parametrised sequencer for an N×N output-stationary PE array. Successor to the fixed 4×4 control unit.
- Holds an ap_start/ap_done handshake. Reads one packed column of A and one packed row of B per cycle, skews them into the array edges, drains the array, then writes all N*N accumulators to the output bank.
- Sits between the A/B/O data memories and the PE grid.

Parameters:
- N, 4, array dimension (rows = cols = N), 2..16.
- DW, 16, element width.
- KMAX, 16, maximum inner dimension.
- ACCW, 2*DW+$clog2(KMAX), accumulator/result width.
- AW, 16, memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- ap_start  in  1  start request, sampled only in IDLE.
- k_len  in  $clog2(KMAX)+1  inner dimension, latched on start.
- o_base  in  AW  output-bank base address, latched on start.
- ap_done  out  1  one-cycle pulse when writeback completes.
- ap_idle  out  1  high in IDLE.
- a_addr  out  AW  A-bank read address; word k = column k of A, packed, row 0 in LSBs.
- b_addr  out  AW  B-bank read address; word k = row k of B, packed, col 0 in LSBs.
- ab_ren  out  1  read enable for both banks.
- a_rdata  in  N*DW  A read data, valid 1 cycle after ab_ren.
- b_rdata  in  N*DW  B read data, valid 1 cycle after ab_ren.
- pe_clr  out  1  synchronous clear of all PE accumulators.
- pe_en  out  1  PE advance/accumulate enable.
- row_in  out  N*DW  west-edge feed, row i at bits [i*DW +: DW].
- col_in  out  N*DW  north-edge feed, column j at bits [j*DW +: DW].
- pe_acc  in  N*N*ACCW  accumulator of PE(i,j) at [(i*N+j)*ACCW +: ACCW].
- o_we  out  1  output-bank write enable.
- o_addr  out  AW  output-bank write address.
- o_wdata  out  ACCW  output-bank write data.

Behaviour:
- Reset values: state IDLE, ap_idle=1, all other outputs 0, skew registers 0, counters 0.
- rst mid-operation aborts immediately to IDLE with no ap_done and no further writes.
- State IDLE:
  - ap_start=1 latches k_eff = min(k_len, KMAX) and o_base, then goes to CLEAR.
  - ap_start in any other state is ignored.
- State CLEAR (1 cycle): pe_clr=1, pe_en=0, skew registers cleared. Goes to FEED, or to DRAIN if k_eff==0.
- State FEED (k_eff cycles):
  - ab_ren=1; a_addr = b_addr = k for k = 0..k_eff-1.
  - pe_en=1 in every cycle.
- State DRAIN (2N-1 cycles):
  - ab_ren=0; pe_en=1; zeros enter the skew inputs.
  - 2N-1 = 1 (read latency) + (N-1) (skew) + (N-1) (propagation).
- Skew, applied on cycles where pe_en=1:
  - row_in[i] = A element i delayed i cycles after read-data valid.
  - col_in[j] = B element j delayed j cycles after read-data valid.
  - Lane 0 has no extra delay.
  - The cycle before first read data, and after the last, feed zeros.
- State WB (N*N cycles, pe_en=0):
  - o_we=1; o_addr = o_base + i*N + j; o_wdata = pe_acc(i,j).
  - Row-major order, one word per cycle.
  - o_addr wraps modulo 2^AW.
- State DONE (1 cycle): ap_done=1, then IDLE. ap_start is first sampled the following cycle.
- Latency, ap_start accepted to ap_done high: 1 + k_eff + (2N-1) + N*N + 1 cycles. N=4, k=4 gives 29.
- Arithmetic: the block performs none; accumulation width is owned by the PE. The DRAIN count is fixed by N, independent of k_eff.

Decomposition:
- Shared package holds:
  - state enum (IDLE, CLEAR, FEED, DRAIN, WB, DONE);
  - DW/ACCW/AW defaults;
  - helper constant DRAIN_LEN = 2N-1.
- One natural sub-module: skew_buffer, parameters N and DW. Triangular shift register, lane i depth i, with enable and synchronous clear. Instantiated twice (rows, columns).

Test Plan:
- N=4, k_len=4, A=identity, B[r][c]=r*4+c+1, o_base=0x100, with a behavioural PE-array model.
  - Required: output words 0x100..0x10F = 1..16 in order.
  - Required: ap_done exactly 29 cycles after start.
- k_len=1, A col0 = {1,2,3,4}, B row0 = {5,6,7,8} → O[i*4+j] = (i+1)*(j+5), e.g. O[15]=32; 16 writes.
- k_len=0 → 16 writes of 0, no ab_ren ever asserted; ap_done after 1+0+7+16+1 = 25 cycles.
- k_len=20 with KMAX=16 → exactly 16 FEED reads (addresses 0..15); result equals the k=16 product.
- ap_start held high through a whole run → a single ap_done, then a second run starts the cycle after DONE; second ap_start mid-FEED produces no extra writes.
- rst asserted on the 3rd FEED cycle → next cycle all outputs 0 and ap_idle=1; no o_we or ap_done follows; a fresh start gives correct results.
